hazard_unit: RTL

Pipeline hazard controller for the five-stage CPU. It sits beside the ID stage, keeps its own scoreboard of the destination registers held in the EX, MEM and WB stages, and drives three things: a load-use stall, forwarding selects for the two EX operand muxes, and a flush on a taken branch resolved in EX. It is the only block that sequences bubbles into the ID/EX register.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/hazard_match.sv | 16 +
 rtl/hazard_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: forwarding select encodings and scoreboard slot.
package pipe_pkg;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic       valid;
      logic       wreg;
      logic       m2reg;
      logic [4:0] dest;
   } sb_slot_t;

   // Youngest producer wins: a non-load in EX beats anything in MEM.
   function automatic fwd_sel_e fwd_select(input logic ex_hit,
                                           input logic ex_load,
                                           input logic mem_hit);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (ex_hit && !ex_load) begin
         sel = FWD_EXMEM;
      end else if (mem_hit) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator: does a scoreboard slot produce source register r?
module hazard_match (
   input  logic       valid,
   input  logic       wreg,
   input  logic [4:0] dest,
   input  logic [4:0] r,
   input  logic       use_r,
   output logic       hit
);

   // Register 0 is hardwired, so it can never carry a dependency.
   always_comb begin
      hit = valid & wreg & use_r & (dest == r) & (r != 5'd0);
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use / RAW stall, EX operand forwarding
// selects, taken-branch flush and saturating event counters.
module hazard_unit #(
   parameter bit          FORWARD_EN = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wreg,
   input  logic             id_m2reg,
   input  logic [4:0]       id_destR,
   input  logic             ex_branch,
   input  logic             ex_zero,
   output logic             stall,
   output logic             flush_ifid,
   output logic             bubble_idex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import pipe_pkg::*;

   sb_slot_t sb_ex, sb_mem, sb_wb;
   logic     ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
   logic     taken, raw_hazard;
   fwd_sel_e fwd_a_nxt, fwd_b_nxt;

   // The register file writes on the falling edge, so the WB slot never
   // matches; it and the MEM load flag are tracked but not consumed.
   logic unused_sb;
   assign unused_sb = ^{sb_mem.m2reg, sb_wb};

   hazard_match u_ex_rs (
      .valid (sb_ex.valid), .wreg (sb_ex.wreg), .dest (sb_ex.dest),
      .r     (id_rs),       .use_r(id_use_rs), .hit  (ex_hit_rs)
   );

   hazard_match u_ex_rt (
      .valid (sb_ex.valid), .wreg (sb_ex.wreg), .dest (sb_ex.dest),
      .r     (id_rt),       .use_r(id_use_rt), .hit  (ex_hit_rt)
   );

   hazard_match u_mem_rs (
      .valid (sb_mem.valid), .wreg (sb_mem.wreg), .dest (sb_mem.dest),
      .r     (id_rs),        .use_r(id_use_rs),  .hit  (mem_hit_rs)
   );

   hazard_match u_mem_rt (
      .valid (sb_mem.valid), .wreg (sb_mem.wreg), .dest (sb_mem.dest),
      .r     (id_rt),        .use_r(id_use_rt),  .hit  (mem_hit_rt)
   );

   // Stall / flush / bubble decision; a taken branch overrides any stall.
   always_comb begin
      taken      = ex_branch & ex_zero;
      raw_hazard = 1'b0;
      if (FORWARD_EN) begin
         raw_hazard = (ex_hit_rs | ex_hit_rt) & sb_ex.m2reg;
      end else begin
         raw_hazard = ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt;
      end
      stall       = ~taken & id_valid & raw_hazard;
      flush_ifid  = taken;
      bubble_idex = stall | taken;
   end

   // Forward selects for the instruction about to enter EX.
   always_comb begin
      fwd_a_nxt = FWD_RF;
      fwd_b_nxt = FWD_RF;
      if (FORWARD_EN && !bubble_idex) begin
         fwd_a_nxt = fwd_select(ex_hit_rs, sb_ex.m2reg, mem_hit_rs);
         fwd_b_nxt = fwd_select(ex_hit_rt, sb_ex.m2reg, mem_hit_rt);
      end
   end

   // Forward select registers track the ID/EX contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a <= '0;
         fwd_b <= '0;
      end else begin
         fwd_a <= fwd_a_nxt;
         fwd_b <= fwd_b_nxt;
      end
   end

   // Scoreboard shift: ID -> EX -> MEM -> WB, bubbles enter as invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_ex  <= '0;
         sb_mem <= '0;
         sb_wb  <= '0;
      end else begin
         sb_wb  <= sb_mem;
         sb_mem <= sb_ex;
         if (id_valid && !bubble_idex) begin
            sb_ex <= '{valid: 1'b1, wreg: id_wreg, m2reg: id_m2reg, dest: id_destR};
         end else begin
            sb_ex <= '0;
         end
      end
   end

   // Saturating stall and flush event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (taken && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule
